// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-schedule slice.
// rc4_ksa consumes the optional macro RC4_KSA_FAST_SWAP_EN.
package rc4_pkg;

    localparam int S_SIZE        = 256;
    localparam int S_ADDR_W      = 8;
    localparam int DEF_KEY_BYTES = 3;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_RD_I,
        KSA_WAIT_I,
        KSA_LAT_I,
        KSA_RD_J,
        KSA_WAIT_J,
        KSA_LAT_J,
        KSA_WR_I,
        KSA_WR_J,
        KSA_DONE
    } ksa_state_t;

    // Width of the key-byte index; a one-byte key still needs one bit.
    function automatic int key_idx_w(input int key_bytes);
        return (key_bytes > 1) ? $clog2(key_bytes) : 1;
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rc4_key_byte_sel: picks key byte k from secret_key, byte 0 in the MSBs.
// Pure combinational; the caller keeps k in 0..KEY_BYTES-1.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES,
    parameter int K_W       = key_idx_w(DEF_KEY_BYTES)
) (
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [K_W-1:0]         k,
    output logic [7:0]             key_byte
);

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k == K_W'(b)) begin
                key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key scheduling over a single-port S memory, start/done handshake.
// Define RC4_KSA_FAST_SWAP_EN to skip the memory swap when j lands on i.
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_ksa,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             s_q,
    output logic [S_ADDR_W-1:0]    s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    output logic                   ksa_busy,
    output logic                   ksa_done
);

    localparam int K_W = key_idx_w(KEY_BYTES);

    ksa_state_t     state;
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     si;
    logic [7:0]     sj;
    logic [K_W-1:0] k;

    logic [7:0]     key_byte;
    logic [7:0]     j_next;
    logic [K_W-1:0] k_next;
    logic           last_i;

    rc4_key_byte_sel #(
        .KEY_BYTES(KEY_BYTES),
        .K_W      (K_W)
    ) u_key_sel (
        .secret_key(secret_key),
        .k         (k),
        .key_byte  (key_byte)
    );

    assign j_next = j + s_q + key_byte;
    assign k_next = (k == K_W'(KEY_BYTES - 1)) ? '0 : k + K_W'(1);
    assign last_i = (i == 8'(S_SIZE - 1));

    // Outputs are registered from the current state, so they trail it by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= KSA_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            s_address <= '0;
            s_data    <= '0;
            s_wren    <= 1'b0;
            ksa_busy  <= 1'b0;
            ksa_done  <= 1'b0;
        end else begin
            s_wren   <= 1'b0;
            s_data   <= '0;
            ksa_busy <= (state != KSA_IDLE) && (state != KSA_DONE);
            ksa_done <= (state == KSA_DONE);

            unique case (state)
                KSA_IDLE: begin
                    if (start_ksa) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= KSA_RD_I;
                    end
                end

                KSA_RD_I: begin
                    s_address <= i;
                    state     <= KSA_WAIT_I;
                end

                KSA_WAIT_I: begin
                    state <= KSA_LAT_I;
                end

                KSA_LAT_I: begin
                    si <= s_q;
                    j  <= j_next;
`ifdef RC4_KSA_FAST_SWAP_EN
                    if (j_next == i) begin
                        i     <= i + 8'd1;
                        k     <= k_next;
                        state <= last_i ? KSA_DONE : KSA_RD_I;
                    end else begin
                        state <= KSA_RD_J;
                    end
`else
                    state <= KSA_RD_J;
`endif
                end

                KSA_RD_J: begin
                    s_address <= j;
                    state     <= KSA_WAIT_J;
                end

                KSA_WAIT_J: begin
                    state <= KSA_LAT_J;
                end

                KSA_LAT_J: begin
                    sj    <= s_q;
                    state <= KSA_WR_I;
                end

                KSA_WR_I: begin
                    s_address <= i;
                    s_data    <= sj;
                    s_wren    <= 1'b1;
                    state     <= KSA_WR_J;
                end

                // i==j needs no special case: both writes carry the same byte.
                KSA_WR_J: begin
                    s_address <= j;
                    s_data    <= si;
                    s_wren    <= 1'b1;
                    i         <= i + 8'd1;
                    k         <= k_next;
                    state     <= last_i ? KSA_DONE : KSA_RD_I;
                end

                KSA_DONE: begin
                    if (!start_ksa) begin
                        state <= KSA_IDLE;
                    end
                end

                default: begin
                    state <= KSA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa.sv
// tb_rc4_ksa: drives rc4_ksa against a behavioural S memory and a software KSA model.
// Honours RC4_KSA_FAST_SWAP_EN when computing expected run lengths.
module tb_rc4_ksa;
    import rc4_pkg::*;

    localparam int KB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_ksa;
    logic [23:0]   secret_key;
    logic [7:0]    s_q;
    logic [7:0]    s_address;
    logic [7:0]    s_data;
    logic          s_wren;
    logic          ksa_busy;
    logic          ksa_done;

    logic          init_req;
    logic [7:0]    mem [0:255];
    logic [15:0]   wlog [0:4095];
    int            wr_count = 0;

    int            checks = 0;
    int            failures = 0;
    logic [7:0]    exp_s [0:255];
    logic [7:0]    exp_q [$];
    logic [15:0]   exp_wr [$];
    int            last_self;

    always #5 clk = ~clk;

    rc4_ksa #(.KEY_BYTES(KB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_ksa (start_ksa),
        .secret_key(secret_key),
        .s_q       (s_q),
        .s_address (s_address),
        .s_data    (s_data),
        .s_wren    (s_wren),
        .ksa_busy  (ksa_busy),
        .ksa_done  (ksa_done)
    );

    // Single-port memory: registered read data, write on the clock edge.
    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        s_q <= mem[s_address];
        if (s_wren) begin
            wlog[wr_count % 4096] <= {s_address, s_data};
            wr_count <= wr_count + 1;
        end
    end

    function automatic int ksa_model(input logic [23:0] key);
        logic [7:0] s [0:255];
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        int n;
        n = 0;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(KB-1-(i%KB)) +: 8];
            j = j + s[i] + kb;
            if (j == 8'(i)) n++;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int a = 0; a < 256; a++) exp_s[a] = s[a];
        return n;
    endfunction

    function automatic int exp_cycles(input int n);
`ifdef RC4_KSA_FAST_SWAP_EN
        return 2049 - 5 * n;
`else
        return 2049 + 0 * n;
`endif
    endfunction

    function automatic int s_mismatches();
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            e = exp_q.pop_front();
            if (mem[a] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic do_init();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic run_ksa(input logic [23:0] key, input bit hold,
                           input int pulse_at,
                           output int cyc, output int busy_cyc);
        secret_key = key;
        last_self = ksa_model(key);
        for (int a = 0; a < 256; a++) exp_q.push_back(exp_s[a]);
        @(negedge clk);
        start_ksa = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_ksa = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold && cyc == pulse_at) start_ksa = 1'b1;
            if (!hold && cyc == pulse_at + 1) start_ksa = 1'b0;
            if (ksa_busy) busy_cyc++;
            if (ksa_done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_ksa = 1'b0;
        init_req = 1'b0;
        secret_key = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_address !== 8'd0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=00", s_address);
        end
        checks++;
        if (s_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", s_data);
        end
        checks++;
        if (s_wren !== 1'b0) begin
            failures++;
            $display("FAIL reset_wren got=%b exp=0", s_wren);
        end
        checks++;
        if (ksa_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", ksa_busy);
        end
        checks++;
        if (ksa_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", ksa_done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ksa_busy, ksa_done, s_wren} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=000",
                     {ksa_busy, ksa_done, s_wren});
        end
    endtask

    task automatic test_key_249();
        int cyc;
        int bc;
        int base;
        int bad;
        logic [15:0] e;
        do_init();
`ifndef RC4_KSA_FAST_SWAP_EN
        exp_wr.push_back(16'h0000);
        exp_wr.push_back(16'h0000);
`endif
        exp_wr.push_back(16'h0103);
        exp_wr.push_back(16'h0301);
        base = wr_count;
        run_ksa(24'h000249, 1'b0, -10, cyc, bc);
        checks++;
        if (cyc != exp_cycles(last_self)) begin
            failures++;
            $display("FAIL k249_cycles got=%0d exp=%0d", cyc, exp_cycles(last_self));
        end
        for (int n = 0; exp_wr.size() > 0; n++) begin
            e = exp_wr.pop_front();
            checks++;
            if (wlog[(base + n) % 4096] !== e) begin
                failures++;
                $display("FAIL k249_write%0d got=%h exp=%h",
                         n, wlog[(base + n) % 4096], e);
            end
        end
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL k249_s_array got=%0d_bad_bytes exp=0", bad);
        end
    endtask

    task automatic test_key_ffffff();
        int cyc;
        int bc;
        int bad;
        do_init();
        run_ksa(24'hFFFFFF, 1'b0, -10, cyc, bc);
        checks++;
        if (cyc != exp_cycles(last_self)) begin
            failures++;
            $display("FAIL kff_cycles got=%0d exp=%0d", cyc, exp_cycles(last_self));
        end
        checks++;
        if (bc != exp_cycles(last_self) - 1) begin
            failures++;
            $display("FAIL kff_busy got=%0d exp=%0d", bc, exp_cycles(last_self) - 1);
        end
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL kff_s_array got=%0d_bad_bytes exp=0", bad);
        end
    endtask

    task automatic test_random_keys();
        int cyc;
        int bc;
        int bad;
        logic [23:0] key;
        for (int r = 0; r < 2; r++) begin
            key = 24'($urandom);
            do_init();
            run_ksa(key, 1'b0, -10, cyc, bc);
            checks++;
            if (cyc != exp_cycles(last_self)) begin
                failures++;
                $display("FAIL rand%0d_cycles key=%h got=%0d exp=%0d",
                         r, key, cyc, exp_cycles(last_self));
            end
            bad = s_mismatches();
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand%0d_s_array key=%h got=%0d_bad_bytes exp=0",
                         r, key, bad);
            end
        end
    endtask

    task automatic test_held_start();
        int cyc;
        int bc;
        int bad;
        int base;
        do_init();
        run_ksa(24'h1A2B3C, 1'b1, -10, cyc, bc);
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL held_s_array got=%0d_bad_bytes exp=0", bad);
        end
        base = wr_count;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ksa_done !== 1'b1 || ksa_busy !== 1'b0) begin
            failures++;
            $display("FAIL held_done got=%b%b exp=10", ksa_done, ksa_busy);
        end
        checks++;
        if (wr_count != base) begin
            failures++;
            $display("FAIL held_no_writes got=%0d exp=0", wr_count - base);
        end
        start_ksa = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ksa_done !== 1'b0) begin
            failures++;
            $display("FAIL held_release got=%b exp=0", ksa_done);
        end
        do_init();
        run_ksa(24'h1A2B3C, 1'b0, -10, cyc, bc);
        checks++;
        if (cyc != exp_cycles(last_self)) begin
            failures++;
            $display("FAIL rerun_cycles got=%0d exp=%0d", cyc, exp_cycles(last_self));
        end
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rerun_s_array got=%0d_bad_bytes exp=0", bad);
        end
    endtask

    task automatic test_busy_pulse();
        int cyc;
        int bc;
        int bad;
        do_init();
        run_ksa(24'h5EED01, 1'b0, 700, cyc, bc);
        checks++;
        if (cyc != exp_cycles(last_self)) begin
            failures++;
            $display("FAIL pulse_cycles got=%0d exp=%0d", cyc, exp_cycles(last_self));
        end
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pulse_s_array got=%0d_bad_bytes exp=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bc;
        int bad;
        int w;
        do_init();
        run_ksa(24'hC0FFEE, 1'b0, -10, cyc, bc);
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pre_rst_s_array got=%0d_bad_bytes exp=0", bad);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({s_address, s_data, s_wren, ksa_busy, ksa_done} !== 19'd0) begin
            failures++;
            $display("FAIL rst_in_done got=%h exp=0",
                     {s_address, s_data, s_wren, ksa_busy, ksa_done});
        end
        @(negedge clk);
        reset = 1'b1;
        do_init();
        secret_key = 24'h77AA55;
        @(negedge clk);
        start_ksa = 1'b1;
        @(posedge clk);
        #1;
        start_ksa = 1'b0;
        repeat (300) @(posedge clk);
        w = 0;
        while (w < 64) begin
            @(posedge clk);
            #1;
            w++;
            if (dut.state == KSA_WR_I) break;
        end
        checks++;
        if (w >= 64) begin
            failures++;
            $display("FAIL wait_wr_i got=timeout exp=WR_I");
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({s_address, s_data, s_wren, ksa_busy, ksa_done} !== 19'd0) begin
            failures++;
            $display("FAIL rst_in_wr_i got=%h exp=0",
                     {s_address, s_data, s_wren, ksa_busy, ksa_done});
        end
        @(negedge clk);
        reset = 1'b1;
        do_init();
        run_ksa(24'h77AA55, 1'b0, -10, cyc, bc);
        checks++;
        if (cyc != exp_cycles(last_self)) begin
            failures++;
            $display("FAIL post_rst_cycles got=%0d exp=%0d", cyc, exp_cycles(last_self));
        end
        bad = s_mismatches();
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_rst_s_array got=%0d_bad_bytes exp=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_key_249();
        test_key_ffffff();
        test_random_keys();
        test_held_start();
        test_busy_pulse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
